// File: rtl/i2c_lut_sequencer_if.sv
// Byte-level I2C register-write channel between the LUT sequencer (master side)
// and the I2C write engine (slave side).
interface i2c_lut_sequencer_if;
   logic        i2c_req;
   logic [7:0]  i2c_dev_addr;
   logic [15:0] i2c_reg_addr;
   logic [7:0]  i2c_reg_data;
   logic        i2c_ack;
   logic        i2c_nack;

   modport master (
      output i2c_req, i2c_dev_addr, i2c_reg_addr, i2c_reg_data,
      input  i2c_ack, i2c_nack
   );

   modport slave (
      input  i2c_req, i2c_dev_addr, i2c_reg_addr, i2c_reg_data,
      output i2c_ack, i2c_nack
   );
endinterface

// File: rtl/i2c_lut_sequencer.sv
// Walks the camera configuration LUT and issues one I2C register write per entry,
// with power-up wait, delay/terminator entries, bounded NACK retry and restart.
module i2c_lut_sequencer #(
   parameter int INDEX_W    = 10,
   parameter int LUT_DEPTH  = 256,
   parameter int INIT_DELAY = 1000000,
   parameter int RETRY_MAX  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [INDEX_W-1:0]   lut_index,
   input  logic [31:0]          lut_data,
   i2c_lut_sequencer_if.master  i2c,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [INDEX_W-1:0]   err_index
);

   localparam int PWR_W   = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
   localparam int CNT_W   = (PWR_W > 24) ? PWR_W : 24;
   localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

   localparam logic [CNT_W-1:0]   PWR_LAST   = CNT_W'((INIT_DELAY > 0) ? INIT_DELAY - 1 : 0);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX);
   localparam logic [INDEX_W:0]   DEPTH      = (INDEX_W + 1)'(LUT_DEPTH);

   localparam logic [2:0] S_PWR_WAIT = 3'd0;
   localparam logic [2:0] S_FETCH    = 3'd1;
   localparam logic [2:0] S_DECODE   = 3'd2;
   localparam logic [2:0] S_WRITE    = 3'd3;
   localparam logic [2:0] S_DELAY    = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
   localparam logic [2:0] S_ERROR    = 3'd6;

   logic [2:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retry_cnt;
   logic [31:0]        entry;
   logic [INDEX_W:0]   next_index;
   logic               at_end;

   // One extra bit so the end-of-table compare never sees a wrapped index.
   assign next_index = {1'b0, lut_index} + 1'b1;
   assign at_end     = (next_index == DEPTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= S_PWR_WAIT;
         cnt              <= '0;
         retry_cnt        <= '0;
         entry            <= '0;
         lut_index        <= '0;
         i2c.i2c_req      <= 1'b0;
         i2c.i2c_dev_addr <= '0;
         i2c.i2c_reg_addr <= '0;
         i2c.i2c_reg_data <= '0;
         busy             <= 1'b1;
         done             <= 1'b0;
         error            <= 1'b0;
         err_index        <= '0;
      end else begin
         case (state)
            S_PWR_WAIT: begin
               if (cnt == PWR_LAST) begin
                  cnt       <= '0;
                  lut_index <= '0;
                  retry_cnt <= '0;
                  state     <= S_FETCH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_FETCH: begin
               entry <= lut_data;
               state <= S_DECODE;
            end

            S_DECODE: begin
               if (entry[31:24] == 8'hFF) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end else if (entry[31:24] == 8'h00) begin
                  cnt   <= CNT_W'(entry[23:0]);
                  state <= S_DELAY;
               end else begin
                  i2c.i2c_dev_addr <= entry[31:24];
                  i2c.i2c_reg_addr <= entry[23:8];
                  i2c.i2c_reg_data <= entry[7:0];
                  i2c.i2c_req      <= 1'b1;
                  state            <= S_WRITE;
               end
            end

            // A low request here is the single-cycle gap before a retry.
            S_WRITE: begin
               if (!i2c.i2c_req) begin
                  i2c.i2c_req <= 1'b1;
               end else if (i2c.i2c_ack) begin
                  i2c.i2c_req <= 1'b0;
                  if (!i2c.i2c_nack) begin
                     retry_cnt <= '0;
                     if (at_end) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                     end else begin
                        lut_index <= next_index[INDEX_W-1:0];
                        state     <= S_FETCH;
                     end
                  end else if (retry_cnt != RETRY_LAST) begin
                     retry_cnt <= retry_cnt + 1'b1;
                  end else begin
                     err_index <= lut_index;
                     error     <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_ERROR;
                  end
               end
            end

            S_DELAY: begin
               if (cnt == '0) begin
                  if (at_end) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     lut_index <= next_index[INDEX_W-1:0];
                     state     <= S_FETCH;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_DONE, S_ERROR: begin
               if (start) begin
                  done      <= 1'b0;
                  error     <= 1'b0;
                  err_index <= '0;
                  lut_index <= '0;
                  retry_cnt <= '0;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  state     <= S_PWR_WAIT;
               end
            end

            default: begin
               state <= S_PWR_WAIT;
            end
         endcase
      end
   end

endmodule
